// File: rtl/net_delay_scheduler.sv
// Cycle-based model of a delayed net `w = a & b` with either inertial
// (glitch-rejecting) or transport (event-replaying) delay semantics.
module net_delay_scheduler #(
  parameter int DELAY  = 10,
  parameter int CNT_W  = 8,
  parameter int QDEPTH = 4,
  localparam int PW    = $clog2(QDEPTH + 1),
  localparam int AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          b,
  input  logic          mode,
  output logic          w,
  output logic          busy,
  output logic [PW-1:0] pending_cnt,
  output logic          overflow
);

  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic [PW-1:0]    FULL      = PW'(QDEPTH);
  localparam logic [CNT_W-1:0] DLY       = CNT_W'(DELAY);
  localparam logic [CNT_W-1:0] DLY_M1    = CNT_W'(DELAY - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               target_q, target_d;
  logic               w_q, w_d;
  logic               r_q, r_q_d;
  logic [CNT_W-1:0]   now_q;
  logic               mode_q;
  logic               ovf_q, ovf_d;
  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]      count_q, count_d;
  logic               q_val [QDEPTH];
  logic [CNT_W-1:0]   q_rel [QDEPTH];

  logic r;
  logic mode_switch;
  logic push, pop;

  assign r           = a & b;
  assign mode_switch = (mode != mode_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    w_d      = w_q;
    r_q_d    = r_q;
    ovf_d    = ovf_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (mode_switch) begin
      // Flush everything; the new mode starts from the current net value.
      state_d = IDLE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      r_q_d   = w_q;
    end else if (!mode) begin
      unique case (state_q)
        IDLE: begin
          if (r != w_q) begin
            target_d = r;
            cnt_d    = DLY_M1;
            state_d  = ARMED;
          end
        end
        ARMED: begin
          if (r != target_q) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            w_d     = target_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      // Pop is resolved before push so a full queue can accept on a pop edge.
      pop = (count_q != '0) && (q_rel[head_q] == now_q);
      if (pop) begin
        w_d    = q_val[head_q];
        head_d = head_q + 1'b1;
      end
      if (r != r_q) begin
        r_q_d = r;
        if ((count_q != FULL) || pop) begin
          push   = 1'b1;
          tail_d = tail_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      count_d = count_q + PW'(push) - PW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= 1'b0;
      w_q      <= 1'b0;
      r_q      <= 1'b0;
      now_q    <= '0;
      mode_q   <= mode;
      ovf_q    <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      w_q      <= w_d;
      r_q      <= r_q_d;
      now_q    <= now_q + 1'b1;
      mode_q   <= mode;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // Queue storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_val[tail_q] <= r;
      q_rel[tail_q] <= now_q + DLY;
    end
  end

  assign w           = w_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == ARMED) || (count_q != '0);
  assign pending_cnt = count_q + PW'(state_q == ARMED);

endmodule

// File: tb/tb_net_delay_scheduler.sv
// Directed bench: stimulus pushes expected w transitions {value, edge};
// per-instance monitors pop and compare whenever w changes.
module tb_net_delay_scheduler;

  localparam int D0 = 10;
  localparam int D1 = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       a0, b0, mode0, a1, b1, mode1;
  logic       w0, busy0, ovf0, w1, busy1, ovf1;
  logic [2:0] pend0, pend1;

  int         cyc = 0;
  logic [3:0] now_m = '0;
  int         checks = 0;
  int         errors = 0;
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  logic        w0_prev = 1'b0;
  logic        w1_prev = 1'b0;

  net_delay_scheduler #(.DELAY(D0), .CNT_W(4), .QDEPTH(4)) u0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .mode(mode0),
    .w(w0), .busy(busy0), .pending_cnt(pend0), .overflow(ovf0)
  );

  net_delay_scheduler #(.DELAY(D1), .CNT_W(8), .QDEPTH(4)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .mode(mode1),
    .w(w1), .busy(busy1), .pending_cnt(pend1), .overflow(ovf1)
  );

  // Clock / edge counter / timestamp model
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc = cyc + 1;
    now_m <= rst ? 4'd0 : now_m + 4'd1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [16:0] ev(input logic v, input int c);
    ev = {v, c[15:0]};
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (!rst && (w0 !== w0_prev)) begin
      logic [16:0] e;
      checks++;
      if (exp_q0.size() == 0) begin
        errors++;
        $display("FAIL u0_w_unexpected: w=%0b at edge %0d, required no change", w0, cyc);
      end else begin
        e = exp_q0.pop_front();
        if (e[16] !== w0 || e[15:0] !== cyc[15:0]) begin
          errors++;
          $display("FAIL u0_w_event: w=%0b at edge %0d, required w=%0b at edge %0d",
                   w0, cyc, e[16], e[15:0]);
        end
      end
    end
    w0_prev = w0;
  end

  always @(negedge clk) begin
    if (!rst && (w1 !== w1_prev)) begin
      logic [16:0] e;
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL u1_w_unexpected: w=%0b at edge %0d, required no change", w1, cyc);
      end else begin
        e = exp_q1.pop_front();
        if (e[16] !== w1 || e[15:0] !== cyc[15:0]) begin
          errors++;
          $display("FAIL u1_w_event: w=%0b at edge %0d, required w=%0b at edge %0d",
                   w1, cyc, e[16], e[15:0]);
        end
      end
    end
    w1_prev = w1;
  end

  // Stimulus
  initial begin
    rst = 1'b1; a0 = 0; b0 = 0; mode0 = 0; a1 = 0; b1 = 0; mode1 = 1;
    tick(3);
    rst = 1'b0;
    check("rst_w0", w0, 0);       check("rst_busy0", busy0, 0);
    check("rst_pend0", pend0, 0); check("rst_ovf0", ovf0, 0);
    check("rst_w1", w1, 0);       check("rst_ovf1", ovf1, 0);

    // Transport overflow on u1: b toggles for 6 edges, only 4 fit
    a1 = 1;
    for (int i = 0; i < 6; i++) begin
      b1 = (i % 2 == 0);
      if (i < 4) exp_q1.push_back(ev(b1, cyc + 1 + D1));
      tick(1);
    end
    b1 = 0;
    check("ovf_set", ovf1, 1);
    check("ovf_pend_full", pend1, 4);
    tick(20);
    check("ovf_drained", pend1, 0);
    check("ovf_sticky", ovf1, 1);
    check("ovf_w_final", w1, 0);

    // Inertial stable change on u0
    a0 = 1; b0 = 1;
    exp_q0.push_back(ev(1'b1, cyc + 1 + D0));
    tick(1);
    check("inr_busy_first", busy0, 1);
    check("inr_pend_armed", pend0, 1);
    tick(D0 - 1);
    check("inr_busy_last", busy0, 1);
    check("inr_w_before", w0, 0);
    tick(1);
    check("inr_w_rise", w0, 1);
    check("inr_busy_clear", busy0, 0);
    check("inr_pend_clear", pend0, 0);
    a0 = 0;
    exp_q0.push_back(ev(1'b0, cyc + 1 + D0));
    tick(D0 + 1);
    check("inr_w_fall", w0, 0);

    // Inertial glitch of 4 cycles is rejected
    a0 = 1;
    tick(4);
    check("glitch_busy", busy0, 1);
    a0 = 0;
    tick(1);
    check("glitch_cancel", busy0, 0);
    tick(D0 + 2);
    check("glitch_w", w0, 0);

    // Switch to transport, 3-cycle pulse replay
    mode0 = 1;
    tick(1);
    check("sw_busy", busy0, 0);
    a0 = 1;
    exp_q0.push_back(ev(1'b1, cyc + 1 + D0));
    tick(3);
    a0 = 0;
    exp_q0.push_back(ev(1'b0, cyc + 1 + D0));
    tick(1);
    check("tr_pend_peak", pend0, 2);
    check("tr_busy", busy0, 1);
    tick(D0 + 2);
    check("tr_pend_empty", pend0, 0);
    check("tr_w_after", w0, 0);

    // Single-cycle pulse is still replayed in transport mode
    a0 = 1;
    exp_q0.push_back(ev(1'b1, cyc + 1 + D0));
    tick(1);
    a0 = 0;
    exp_q0.push_back(ev(1'b0, cyc + 1 + D0));
    tick(D0 + 3);

    // Timestamp wrap: event sampled at now=12 releases at now=6
    for (int i = 0; i < 16 && now_m != 4'd12; i++) tick(1);
    check("wrap_sync", now_m, 12);
    a0 = 1;
    exp_q0.push_back(ev(1'b1, cyc + 1 + D0));
    tick(1);
    a0 = 0;
    exp_q0.push_back(ev(1'b0, cyc + 1 + D0));
    tick(D0 + 3);
    check("wrap_drained", pend0, 0);

    // Reset with 3 queued events aborts them
    a0 = 1; tick(1); a0 = 0; tick(1); a0 = 1; tick(1);
    check("rst_q_pend", pend0, 3);
    rst = 1;
    tick(1);
    rst = 0; a0 = 0; b0 = 0;
    check("rst2_w0", w0, 0);      check("rst2_busy0", busy0, 0);
    check("rst2_pend0", pend0, 0); check("rst2_ovf1", ovf1, 0);
    tick(D0 + 2);
    check("rst2_w_held", w0, 0);

    // Mode switch while ARMED flushes, then transport re-evaluates r
    mode0 = 0;
    tick(1);
    a0 = 1; b0 = 1;
    tick(3);
    check("msw_armed", busy0, 1);
    mode0 = 1;
    tick(1);
    check("msw_busy", busy0, 0);
    check("msw_pend", pend0, 0);
    check("msw_w", w0, 0);
    exp_q0.push_back(ev(1'b1, cyc + 1 + D0));
    tick(1);
    a0 = 0;
    exp_q0.push_back(ev(1'b0, cyc + 1 + D0));
    tick(D0 + 3);
    check("msw_end_busy", busy0, 0);

    tick(5);
    check("u0_exp_left", exp_q0.size(), 0);
    check("u1_exp_left", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
